// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: multi-channel servo PWM generator with one shared period
// counter and per-channel shadow/active duty registers. New duties move from
// shadow to active only at the period wrap, or continuously while disabled,
// so a running pulse is never reshaped mid-period.
module servo_pwm_gen #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 20,
    parameter int PERIOD       = 1000000,
    parameter int DUTY_DEFAULT = 75000,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk0,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_duty,
    output logic             wr_err,
    output logic             period_start,
    output logic [NCH-1:0]   pwm_out
);

    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DEFAULT_C = CNT_W'(DUTY_DEFAULT);

    // Saturate a requested high time to one full period (100 % duty).
    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
        return (d > PERIOD_C) ? PERIOD_C : d;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow [NCH];
    logic [CNT_W-1:0] active [NCH];
    logic             wr_ok;
    logic             wr_bad;
    logic             wrap;
    logic             load;
    logic [CNT_W-1:0] wr_clamped;
    logic [NCH-1:0]   pwm_next;

    assign wr_ok      = wr_en && (32'(wr_ch) < 32'(NCH));
    assign wr_bad     = wr_en && !(32'(wr_ch) < 32'(NCH));
    assign wrap       = enable && (cnt == LAST_C);
    // Disabled time keeps active tracking shadow, so a restart begins with
    // the latest programmed duties.
    assign load       = wrap || !enable;
    assign wr_clamped = clamp_duty(wr_duty);

    // Shared period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow duty registers take every valid write immediately.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) shadow[i] <= DEFAULT_C;
        end else if (wr_ok) begin
            shadow[wr_ch] <= wr_clamped;
        end
    end

    // Active duty registers load at period boundaries; a write landing in the
    // load cycle is forwarded so it is not lost for a whole period.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) active[i] <= DEFAULT_C;
        end else if (load) begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ok && (32'(wr_ch) == 32'(i))) begin
                    active[i] <= wr_clamped;
                end else begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Per-channel compare against the current period position.
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_next[i] = enable && (cnt < active[i]);
        end
    end

    // Registered outputs: PWM pins, period marker and invalid-write flag.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            pwm_out      <= pwm_next;
            period_start <= enable && (cnt == '0);
            wr_err       <= wr_bad;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: a period-position reference model
// queues the expected outputs for every clock, a monitor pops and compares.
// A second 3-channel instance exercises the out-of-range channel path.
module tb_servo_pwm_gen;

    localparam int PER = 20;
    localparam int DEF = 5;

    logic       clk0 = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_ch = '0;
    logic [7:0] wr_duty = '0;
    logic       wr_err;
    logic       period_start;
    logic [1:0] pwm_out;

    logic       wr_en_b = 1'b0;
    logic [1:0] wr_ch_b = 2'd3;
    logic       wr_err_b;
    logic       period_start_b;
    logic [2:0] pwm_out_b;

    servo_pwm_gen #(.NCH(2), .CNT_W(8), .PERIOD(PER), .DUTY_DEFAULT(DEF)) dut (
        .clk0(clk0), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_err(wr_err),
        .period_start(period_start), .pwm_out(pwm_out)
    );

    servo_pwm_gen #(.NCH(3), .CNT_W(8), .PERIOD(PER), .DUTY_DEFAULT(DEF)) dut_b (
        .clk0(clk0), .rst_n(rst_n), .enable(enable), .wr_en(wr_en_b),
        .wr_ch(wr_ch_b), .wr_duty(wr_duty), .wr_err(wr_err_b),
        .period_start(period_start_b), .pwm_out(pwm_out_b)
    );

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic [1:0] pwm;
        logic       ps;
        logic       err;
        logic [2:0] pwm_b;
        logic       ps_b;
        logic       err_b;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: position inside the period and per-channel duties.
    int pos;
    int shadow_m [2];
    int act_m [2];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endfunction

    function automatic void model_reset();
        pos = 0;
        for (int i = 0; i < 2; i++) begin
            shadow_m[i] = DEF;
            act_m[i]    = DEF;
        end
    endfunction

    // One clock of stimulus: drive inputs, predict what the next edge must
    // produce, then advance the model past that edge.
    task automatic step(input logic e, input logic we, input logic [0:0] ch,
                        input int d, input logic web);
        exp_t x;
        @(negedge clk0);
        enable  = e;
        wr_en   = we;
        wr_ch   = ch;
        wr_duty = d[7:0];
        wr_en_b = web;
        for (int i = 0; i < 2; i++) x.pwm[i] = e && (pos < act_m[i]);
        x.ps  = e && (pos == 0);
        x.err = 1'b0;
        for (int i = 0; i < 3; i++) x.pwm_b[i] = e && (pos < DEF);
        x.ps_b  = x.ps;
        x.err_b = web;
        if (we) shadow_m[ch] = (d > PER) ? PER : d;
        if (!e || pos == PER - 1) begin
            for (int i = 0; i < 2; i++) act_m[i] = shadow_m[i];
            pos = 0;
        end else begin
            pos++;
        end
        q.push_back(x);
        @(posedge clk0);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 100) begin
            step(1'b1, 1'b0, 1'b0, 0, 1'b0);
            guard++;
        end
        chk("wait_pos_bound", 32'(pos), 32'(p));
    endtask

    // Monitor: compare each edge's outputs with the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk0);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("pwm_out", 32'(pwm_out), 32'(x.pwm));
                chk("period_start", 32'(period_start), 32'(x.ps));
                chk("wr_err", 32'(wr_err), 32'(x.err));
                chk("pwm_out_b", 32'(pwm_out_b), 32'(x.pwm_b));
                chk("period_start_b", 32'(period_start_b), 32'(x.ps_b));
                chk("wr_err_b", 32'(wr_err_b), 32'(x.err_b));
            end
        end
    end

    initial begin
        logic en_r;
        model_reset();
        repeat (3) @(posedge clk0);
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);
        chk("reset_err", 32'(wr_err), 32'd0);
        chk("reset_pwm_b", 32'(pwm_out_b), 32'd0);
        @(negedge clk0);
        rst_n = 1'b1;

        // Default 5 high / 15 low, period_start on each rising edge.
        idle(45);

        // Mid-period write to ch1 only takes effect next period.
        wait_pos(3);
        step(1'b1, 1'b1, 1'b1, 12, 1'b0);
        idle(45);

        // Write landing exactly in the wrap cycle is forwarded.
        wait_pos(19);
        step(1'b1, 1'b1, 1'b0, 8, 1'b0);
        idle(25);

        // Duty 0 and an over-range duty (saturates to 100 %).
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 30, 1'b0);
        idle(45);

        // Out-of-range channel on the 3-channel instance.
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        idle(5);

        // Disable for 7 cycles with a ch1 write inside the gap, then restart.
        wait_pos(2);
        for (int k = 0; k < 7; k++) step(1'b0, (k == 3), 1'b1, 9, 1'b0);
        idle(4);

        // Asynchronous reset while ch1 is high.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_pwm_b", 32'(pwm_out_b), 32'd0);
        chk("async_rst_ps", 32'(period_start), 32'd0);
        @(posedge clk0);
        #1;
        chk("held_rst_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk0);
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_en_b = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        idle(45);

        // Randomised traffic.
        en_r = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if (en_r) en_r = ($urandom_range(0, 99) >= 3);
            else      en_r = ($urandom_range(0, 99) < 30);
            step(en_r, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 30)), ($urandom_range(0, 16) == 0));
        end
        idle(2);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
